driver_rx_decoder: RTL and testbench

Receiver-side model of the TLC5957 serial command interface, synthesizable and clocked in the system domain. It samples the SCLK/LAT/SIN lines the way a driver does, and decodes LAT-length commands (WRTGS, LATGS, WRTFC, LINERESET, READFC, FCWRTEN). It exposes the latched 48-bit words, maintains a function-control register and answers READFC on SOUT. It sits in the FPGA loopback/self-test path, listening to one lane of the drivers bus so that frame formatting and configuration sequences can be checked on hardware.

---
 rtl/driver_rx_decoder_pkg.sv | 31 +++
 rtl/driver_rx_decoder_if.sv | 23 ++
 rtl/driver_rx_decoder_lat_cmd_decode.sv | 24 ++
 rtl/driver_rx_decoder.sv | 171 +++++++++++++++++
 tb/tb_driver_rx_decoder.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/driver_rx_decoder_pkg.sv
// Shared types and constants for the TLC5957 receive-side command decoder.
// Optional frame-length checking is enabled with DRIVER_RX_FRAMECHECK_EN.
package driver_pkg;

    localparam int SR_WIDTH_DEF = 48;
    localparam int CNT_SAT_DEF  = 31;
    localparam int FRAME_EDGES  = 48;

    // Number of SCLK edges seen with LAT high for each command
    localparam int LAT_WRTGS     = 1;
    localparam int LAT_LATGS     = 3;
    localparam int LAT_WRTFC     = 5;
    localparam int LAT_LINERESET = 7;
    localparam int LAT_READFC    = 11;
    localparam int LAT_FCWRTEN   = 15;

    typedef enum logic [2:0] {
        WRTGS     = 3'd0,
        LATGS     = 3'd1,
        WRTFC     = 3'd2,
        LINERESET = 3'd3,
        READFC    = 3'd4,
        FCWRTEN   = 3'd5,
        INVALID   = 3'd7
    } driver_cmd_t;

    function automatic logic is_frame_cmd(input driver_cmd_t c);
        return (c == WRTGS) || (c == LATGS) || (c == WRTFC);
    endfunction

endpackage

// File: rtl/driver_rx_decoder_if.sv
// One lane of the TLC5957 driver bus: SCLK, LAT and SIN from the source, SOUT back.
interface driver_rx_decoder_if;

    logic driver_sclk;
    logic driver_lat;
    logic driver_sin;
    logic driver_sout;

    modport master (
        output driver_sclk,
        output driver_lat,
        output driver_sin,
        input  driver_sout
    );

    modport slave (
        input  driver_sclk,
        input  driver_lat,
        input  driver_sin,
        output driver_sout
    );

endinterface

// File: rtl/driver_rx_decoder_lat_cmd_decode.sv
// Combinational mapping from the LAT-high edge count to a driver command.
module lat_cmd_decode
    import driver_pkg::*;
#(
    parameter int CNT_W = 5
) (
    input  logic [CNT_W-1:0] i_lat_cnt,
    output driver_cmd_t      o_cmd
);

    always_comb begin
        o_cmd = INVALID;
        case (int'(i_lat_cnt))
            LAT_WRTGS:     o_cmd = WRTGS;
            LAT_LATGS:     o_cmd = LATGS;
            LAT_WRTFC:     o_cmd = WRTFC;
            LAT_LINERESET: o_cmd = LINERESET;
            LAT_READFC:    o_cmd = READFC;
            LAT_FCWRTEN:   o_cmd = FCWRTEN;
            default:       o_cmd = INVALID;
        endcase
    end

endmodule

// File: rtl/driver_rx_decoder.sv
// Receiver model of the TLC5957 serial interface: samples SCLK/LAT/SIN, decodes commands,
// keeps the FC register and answers READFC on SOUT. Macro DRIVER_RX_FRAMECHECK_EN adds frame-length checks.
module driver_rx_decoder
    import driver_pkg::*;
#(
    parameter int SR_WIDTH = SR_WIDTH_DEF,
    parameter int CNT_SAT  = CNT_SAT_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    driver_rx_decoder_if.slave   bus,
    output logic                 cmd_valid,
    output driver_cmd_t          cmd,
    output logic [SR_WIDTH-1:0]  word,
    output logic [4:0]           gs_count,
    output logic [SR_WIDTH-1:0]  fc_reg,
    output logic                 err,
    input  logic                 err_clr
);

    localparam int                CNT_W     = $clog2(CNT_SAT + 1);
    localparam logic [CNT_W-1:0]  CNT_SAT_V = CNT_W'(CNT_SAT);

    logic                w_sclk;
    logic                w_lat;
    logic                w_sin;
    logic [SR_WIDTH-1:0] w_sr_next;
    logic                w_cmd_end;
    driver_cmd_t         w_cmd;
    logic                w_proto_err;
    logic                w_frame_err;

    logic [SR_WIDTH-1:0] r_sr;
    logic [SR_WIDTH-1:0] r_snap;
    logic [SR_WIDTH-1:0] r_sout_sr;
    logic [CNT_W-1:0]    r_lat_cnt;
    logic                r_lat_q;
    logic                r_fc_en;
    logic                r_cmd_valid;
    driver_cmd_t         r_cmd;
    logic [SR_WIDTH-1:0] r_word;
    logic [4:0]          r_gs_count;
    logic [SR_WIDTH-1:0] r_fc_reg;
    logic                r_err;

    assign w_sclk    = bus.driver_sclk;
    assign w_lat     = bus.driver_lat;
    assign w_sin     = bus.driver_sin;
    assign w_sr_next = w_sclk ? {r_sr[SR_WIDTH-2:0], w_sin} : r_sr;

    // A LAT pulse with no SCLK edge leaves lat_cnt at zero and is ignored
    assign w_cmd_end = r_lat_q && !w_lat && (r_lat_cnt != '0);

    lat_cmd_decode #(
        .CNT_W (CNT_W)
    ) u_decode (
        .i_lat_cnt (r_lat_cnt),
        .o_cmd     (w_cmd)
    );

    assign w_proto_err = w_cmd_end && ((w_cmd == INVALID) || ((w_cmd == WRTFC) && !r_fc_en));

`ifdef DRIVER_RX_FRAMECHECK_EN
    logic [5:0] r_frame_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_cnt <= '0;
        end else if (w_cmd_end) begin
            r_frame_cnt <= '0;
        end else if (w_sclk && (r_frame_cnt != 6'd63)) begin
            r_frame_cnt <= r_frame_cnt + 6'd1;
        end
    end

    assign w_frame_err = w_cmd_end && is_frame_cmd(w_cmd) && (r_frame_cnt != 6'(FRAME_EDGES));
`else
    assign w_frame_err = 1'b0;
`endif

    // An edge in the command-end cycle still shifts sr, but LAT is low so it is never counted
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sr      <= '0;
            r_snap    <= '0;
            r_lat_q   <= 1'b0;
            r_lat_cnt <= '0;
        end else begin
            r_sr    <= w_sr_next;
            r_lat_q <= w_lat;
            if (w_lat) begin
                r_snap <= w_sr_next;
            end
            if (w_cmd_end) begin
                r_lat_cnt <= '0;
            end else if (w_sclk && w_lat && (r_lat_cnt != CNT_SAT_V)) begin
                r_lat_cnt <= r_lat_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cmd_valid <= 1'b0;
            r_cmd       <= WRTGS;
            r_word      <= '0;
        end else begin
            r_cmd_valid <= w_cmd_end;
            if (w_cmd_end) begin
                r_cmd  <= w_cmd;
                r_word <= r_snap;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_gs_count <= '0;
        end else if (w_cmd_end) begin
            if (w_cmd == WRTGS) begin
                if (r_gs_count != 5'd31) begin
                    r_gs_count <= r_gs_count + 5'd1;
                end
            end else if ((w_cmd == LATGS) || (w_cmd == LINERESET)) begin
                r_gs_count <= '0;
            end
        end
    end

    // FC writes are armed only by the command immediately before them
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fc_en  <= 1'b0;
            r_fc_reg <= '0;
        end else if (w_cmd_end) begin
            r_fc_en <= (w_cmd == FCWRTEN);
            if ((w_cmd == WRTFC) && r_fc_en) begin
                r_fc_reg <= r_snap;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sout_sr <= '0;
        end else if (w_cmd_end && (w_cmd == READFC)) begin
            r_sout_sr <= r_fc_reg;
        end else if (w_sclk) begin
            r_sout_sr <= {r_sout_sr[SR_WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_proto_err || w_frame_err) begin
            r_err <= 1'b1;
        end else if (err_clr) begin
            r_err <= 1'b0;
        end
    end

    assign bus.driver_sout = r_sout_sr[SR_WIDTH-1];
    assign cmd_valid       = r_cmd_valid;
    assign cmd             = r_cmd;
    assign word            = r_word;
    assign gs_count        = r_gs_count;
    assign fc_reg          = r_fc_reg;
    assign err             = r_err;

endmodule

// File: tb/tb_driver_rx_decoder.sv
// Testbench for driver_rx_decoder: directed scenarios plus randomized command streams
// compared with a command-level model; frame checks follow DRIVER_RX_FRAMECHECK_EN.
module tb_driver_rx_decoder;
    import driver_pkg::*;

    localparam int W = 48;

    logic          clk = 1'b0;
    logic          rst;
    logic          err_clr;
    logic          cmd_valid;
    driver_cmd_t   cmd;
    logic [W-1:0]  word;
    logic [4:0]    gs_count;
    logic [W-1:0]  fc_reg;
    logic          err;

    driver_rx_decoder_if bus();

    driver_rx_decoder #(
        .SR_WIDTH (W),
        .CNT_SAT  (31)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .cmd_valid (cmd_valid),
        .cmd       (cmd),
        .word      (word),
        .gs_count  (gs_count),
        .fc_reg    (fc_reg),
        .err       (err),
        .err_clr   (err_clr)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Command-level model: bit history, FC state, GS count, error flag, edges since last command
    logic [W-1:0] m_sr;
    logic [W-1:0] m_fc;
    logic [W-1:0] m_sout;
    logic [W-1:0] m_word;
    driver_cmd_t  m_cmd;
    int           m_gs;
    bit           m_fc_en;
    bit           m_err;
    int           m_frame;

    function automatic driver_cmd_t exp_cmd(input int nlat);
        int c;
        c = (nlat > 31) ? 31 : nlat;
        case (c)
            1:       return WRTGS;
            3:       return LATGS;
            5:       return WRTFC;
            7:       return LINERESET;
            11:      return READFC;
            15:      return FCWRTEN;
            default: return INVALID;
        endcase
    endfunction

    task automatic model_reset();
        m_sr = '0; m_fc = '0; m_sout = '0; m_word = '0; m_cmd = WRTGS;
        m_gs = 0; m_fc_en = 0; m_err = 0; m_frame = 0;
    endtask

    task automatic model_decode(input driver_cmd_t ec);
`ifdef DRIVER_RX_FRAMECHECK_EN
        if (((ec == WRTGS) || (ec == LATGS) || (ec == WRTFC)) && (m_frame != 48)) m_err = 1;
`endif
        case (ec)
            WRTGS:           m_gs = (m_gs < 31) ? m_gs + 1 : 31;
            LATGS, LINERESET: m_gs = 0;
            WRTFC:           if (m_fc_en) m_fc = m_sr; else m_err = 1;
            READFC:          m_sout = m_fc;
            INVALID:         m_err = 1;
            default:         ;
        endcase
        m_fc_en = (ec == FCWRTEN);
        m_frame = 0;
        m_cmd   = ec;
        m_word  = m_sr;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; err_clr = 1'b0;
        bus.driver_sclk = 1'b0; bus.driver_lat = 1'b0; bus.driver_sin = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic drive_edge(input logic b, input logic l, input bit gaps);
        if (gaps && ($urandom_range(0, 3) == 0)) begin
            @(negedge clk);
            bus.driver_sclk = 1'b0;
        end
        @(negedge clk);
        bus.driver_sclk = 1'b1; bus.driver_sin = b; bus.driver_lat = l;
        m_sr   = {m_sr[W-2:0], b};
        m_sout = {m_sout[W-2:0], 1'b0};
        if (m_frame < 63) m_frame++;
    endtask

    // Sends total edges, LAT high on the last nlat; returns one cycle after the decode edge
    task automatic send_cmd(input logic [W-1:0] data, input int total, input int nlat, input bit gaps);
        for (int i = 0; i < total; i++) begin
            int idx;
            idx = total - 1 - i;
            drive_edge((idx < W) ? data[idx] : 1'b0, (i >= total - nlat), gaps);
        end
        @(negedge clk);
        bus.driver_sclk = 1'b0; bus.driver_lat = 1'b0;
        model_decode(exp_cmd(nlat));
        @(negedge clk);
    endtask

    function automatic logic [W-1:0] rand_word();
        return {$urandom(), $urandom()} & {W{1'b1}};
    endfunction

    task automatic test_reset();
        do_reset();
        checks++; if (cmd_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_cmd_valid: got %0h expected 0", cmd_valid); end
        checks++; if (cmd !== WRTGS) begin failures++; $display("[TB] FAIL reset_cmd: got %0d expected 0", cmd); end
        checks++; if (word !== '0) begin failures++; $display("[TB] FAIL reset_word: got %0h expected 0", word); end
        checks++; if (gs_count !== 5'd0) begin failures++; $display("[TB] FAIL reset_gs: got %0d expected 0", gs_count); end
        checks++; if (fc_reg !== '0) begin failures++; $display("[TB] FAIL reset_fc: got %0h expected 0", fc_reg); end
        checks++; if (err !== 1'b0) begin failures++; $display("[TB] FAIL reset_err: got %0h expected 0", err); end
        checks++; if (bus.driver_sout !== 1'b0) begin failures++; $display("[TB] FAIL reset_sout: got %0h expected 0", bus.driver_sout); end
    endtask

    task automatic test_wrtgs();
        do_reset();
        send_cmd(48'hA5A5_0F0F_1234, 48, 1, 1'b1);
        checks++; if (cmd_valid !== 1'b1) begin failures++; $display("[TB] FAIL wrtgs_valid: got %0h expected 1", cmd_valid); end
        checks++; if (cmd !== WRTGS) begin failures++; $display("[TB] FAIL wrtgs_cmd: got %0d expected %0d", cmd, WRTGS); end
        checks++; if (word !== 48'hA5A5_0F0F_1234) begin failures++; $display("[TB] FAIL wrtgs_word: got %0h expected a5a50f0f1234", word); end
        checks++; if (gs_count !== 5'd1) begin failures++; $display("[TB] FAIL wrtgs_gs: got %0d expected 1", gs_count); end
        checks++; if (err !== 1'b0) begin failures++; $display("[TB] FAIL wrtgs_err: got %0h expected 0", err); end
        @(negedge clk);
        checks++; if (cmd_valid !== 1'b0) begin failures++; $display("[TB] FAIL wrtgs_pulse: got %0h expected 0", cmd_valid); end
        checks++; if (word !== 48'hA5A5_0F0F_1234) begin failures++; $display("[TB] FAIL wrtgs_word_hold: got %0h expected a5a50f0f1234", word); end
    endtask

    task automatic test_gs_sequence();
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            send_cmd(rand_word(), 48, 1, 1'b0);
            checks++; if (gs_count !== 5'(i)) begin failures++; $display("[TB] FAIL gs_seq_%0d: got %0d expected %0d", i, gs_count, i); end
        end
        send_cmd(rand_word(), 48, 3, 1'b0);
        checks++; if (cmd !== LATGS) begin failures++; $display("[TB] FAIL gs_latgs_cmd: got %0d expected %0d", cmd, LATGS); end
        checks++; if (gs_count !== 5'd0) begin failures++; $display("[TB] FAIL gs_latgs_clear: got %0d expected 0", gs_count); end
    endtask

    task automatic test_gs_saturation();
        do_reset();
        for (int i = 1; i <= 33; i++) send_cmd(rand_word(), 48, 1, 1'b0);
        checks++; if (gs_count !== 5'd31) begin failures++; $display("[TB] FAIL gs_saturate: got %0d expected 31", gs_count); end
        send_cmd(rand_word(), 48, 7, 1'b0);
        checks++; if (gs_count !== 5'd0 || cmd !== LINERESET) begin failures++; $display("[TB] FAIL linereset: got gs=%0d cmd=%0d expected gs=0 cmd=%0d", gs_count, cmd, LINERESET); end
    endtask

    task automatic test_fc_write();
        do_reset();
        send_cmd('0, 15, 15, 1'b0);
        checks++; if (cmd !== FCWRTEN) begin failures++; $display("[TB] FAIL fcwrten_cmd: got %0d expected %0d", cmd, FCWRTEN); end
        send_cmd(48'h0000_0000_8001, 48, 5, 1'b1);
        checks++; if (fc_reg !== 48'h0000_0000_8001) begin failures++; $display("[TB] FAIL fc_write: got %0h expected 8001", fc_reg); end
        checks++; if (err !== 1'b0) begin failures++; $display("[TB] FAIL fc_write_err: got %0h expected 0", err); end
        send_cmd(48'hFFFF_0000_FFFF, 48, 5, 1'b0);
        checks++; if (err !== 1'b1) begin failures++; $display("[TB] FAIL fc_unarmed_err: got %0h expected 1", err); end
        checks++; if (fc_reg !== 48'h0000_0000_8001) begin failures++; $display("[TB] FAIL fc_unarmed_hold: got %0h expected 8001", fc_reg); end
    endtask

    task automatic test_readfc();
        logic [W-1:0] fcval;
        fcval = 48'h8000_0000_0001;
        do_reset();
        send_cmd('0, 15, 15, 1'b0);
        send_cmd(fcval, 48, 5, 1'b0);
        send_cmd(rand_word(), 11, 11, 1'b0);
        checks++; if (cmd !== READFC) begin failures++; $display("[TB] FAIL readfc_cmd: got %0d expected %0d", cmd, READFC); end
        checks++; if (bus.driver_sout !== 1'b1) begin failures++; $display("[TB] FAIL readfc_sout_0: got %0h expected 1", bus.driver_sout); end
        for (int k = 1; k <= 47; k++) begin
            drive_edge(1'($urandom_range(0, 1)), 1'b0, 1'b0);
            @(posedge clk); #1;
            checks++;
            if (bus.driver_sout !== fcval[W-1-k]) begin
                failures++; $display("[TB] FAIL readfc_sout_%0d: got %0h expected %0h", k, bus.driver_sout, fcval[W-1-k]);
            end
        end
        @(negedge clk);
        bus.driver_sclk = 1'b0;
    endtask

    task automatic test_invalid();
        do_reset();
        send_cmd(rand_word(), 48, 4, 1'b0);
        checks++; if (cmd !== INVALID) begin failures++; $display("[TB] FAIL invalid_cmd: got %0d expected %0d", cmd, INVALID); end
        checks++; if (err !== 1'b1) begin failures++; $display("[TB] FAIL invalid_err: got %0h expected 1", err); end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        m_err = 0;
        checks++; if (err !== 1'b0) begin failures++; $display("[TB] FAIL err_clr: got %0h expected 0", err); end
        // A 33-edge LAT must saturate at 31 rather than wrap onto a valid length
        send_cmd(rand_word(), 48, 33, 1'b0);
        checks++; if (cmd !== INVALID || err !== 1'b1) begin failures++; $display("[TB] FAIL lat_saturate: got cmd=%0d err=%0h expected cmd=%0d err=1", cmd, err, INVALID); end
    endtask

    task automatic test_lat_no_edge();
        bit seen;
        do_reset();
        @(negedge clk); bus.driver_lat = 1'b1;
        @(negedge clk);
        @(negedge clk); bus.driver_lat = 1'b0;
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (cmd_valid !== 1'b0) seen = 1;
        end
        checks++; if (seen) begin failures++; $display("[TB] FAIL lat_no_edge: got cmd_valid=1 expected 0"); end
    endtask

    task automatic test_framecheck();
        bit exp_err;
`ifdef DRIVER_RX_FRAMECHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        do_reset();
        send_cmd(rand_word(), 40, 1, 1'b0);
        checks++; if (cmd !== WRTGS) begin failures++; $display("[TB] FAIL frame_cmd: got %0d expected %0d", cmd, WRTGS); end
        checks++; if (err !== exp_err) begin failures++; $display("[TB] FAIL frame_err: got %0h expected %0h", err, exp_err); end
    endtask

    task automatic test_reset_mid_lat();
        bit seen;
        do_reset();
        send_cmd('0, 15, 15, 1'b0);
        send_cmd(rand_word() | 48'h1, 48, 5, 1'b0);
        send_cmd(rand_word(), 48, 1, 1'b0);
        for (int i = 0; i < 5; i++) drive_edge(1'($urandom_range(0, 1)), 1'b1, 1'b0);
        @(negedge clk);
        rst = 1'b1; bus.driver_sclk = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0; bus.driver_lat = 1'b0;
        model_reset();
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (cmd_valid !== 1'b0) seen = 1;
        end
        checks++; if (seen) begin failures++; $display("[TB] FAIL midlat_valid: got cmd_valid=1 expected 0"); end
        checks++; if (cmd !== WRTGS || word !== '0) begin failures++; $display("[TB] FAIL midlat_cmd_word: got cmd=%0d word=%0h expected 0 0", cmd, word); end
        checks++; if (gs_count !== 5'd0 || fc_reg !== '0) begin failures++; $display("[TB] FAIL midlat_gs_fc: got gs=%0d fc=%0h expected 0 0", gs_count, fc_reg); end
        checks++; if (err !== 1'b0 || bus.driver_sout !== 1'b0) begin failures++; $display("[TB] FAIL midlat_err_sout: got err=%0h sout=%0h expected 0 0", err, bus.driver_sout); end
    endtask

    task automatic test_random();
        int lens[6] = '{1, 3, 5, 7, 11, 15};
        int pick, nlat, total;
        do_reset();
        for (int n = 0; n < 60; n++) begin
            pick = $urandom_range(0, 7);
            nlat = (pick < 6) ? lens[pick] : $urandom_range(1, 40);
            total = ($urandom_range(0, 3) != 0) ? 48 : nlat + $urandom_range(0, 60);
            if (total < nlat) total = nlat;
            if ((nlat == LAT_WRTFC) && ($urandom_range(0, 1) == 1)) send_cmd('0, 15, 15, 1'b1);
            send_cmd(rand_word(), total, nlat, 1'b1);
            checks++; if (cmd_valid !== 1'b1) begin failures++; $display("[TB] FAIL rnd%0d_valid: got %0h expected 1", n, cmd_valid); end
            checks++; if (cmd !== m_cmd) begin failures++; $display("[TB] FAIL rnd%0d_cmd: got %0d expected %0d", n, cmd, m_cmd); end
            checks++; if (word !== m_word) begin failures++; $display("[TB] FAIL rnd%0d_word: got %0h expected %0h", n, word, m_word); end
            checks++; if (gs_count !== 5'(m_gs)) begin failures++; $display("[TB] FAIL rnd%0d_gs: got %0d expected %0d", n, gs_count, m_gs); end
            checks++; if (fc_reg !== m_fc) begin failures++; $display("[TB] FAIL rnd%0d_fc: got %0h expected %0h", n, fc_reg, m_fc); end
            checks++; if (err !== m_err) begin failures++; $display("[TB] FAIL rnd%0d_err: got %0h expected %0h", n, err, m_err); end
            checks++; if (bus.driver_sout !== m_sout[W-1]) begin failures++; $display("[TB] FAIL rnd%0d_sout: got %0h expected %0h", n, bus.driver_sout, m_sout[W-1]); end
        end
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1; err_clr = 1'b0;
        bus.driver_sclk = 1'b0; bus.driver_lat = 1'b0; bus.driver_sin = 1'b0;
        model_reset();
        test_reset();
        test_wrtgs();
        test_gs_sequence();
        test_gs_saturation();
        test_fc_write();
        test_readfc();
        test_invalid();
        test_lat_no_edge();
        test_framecheck();
        test_reset_mid_lat();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
